ln_stage4_out_serializer: RTL and testbench

Output drain for the LayerNorm pipeline, fed by the normalize stage's registered 64x16 result vector and valid pulse. Buffers up to two result vectors and streams each one out as 16 beats of 4 elements on a valid/ready interface toward writeback/memory. The normalize stage has no backpressure, so this block exposes a slot-free flag for upstream trigger gating and a sticky overflow flag for vectors it has to drop.

---
 rtl/ln_stage4_out_serializer_if.sv | 24 ++
 rtl/ln_stage4_out_serializer.sv | 108 ++++++++++
 tb/tb_ln_stage4_out_serializer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ln_stage4_out_serializer_if.sv
// Beat stream from the LayerNorm output serializer toward writeback.
// Valid/ready: a beat transfers on any edge where o_tvalid && i_tready; while
// o_tvalid is high and i_tready low, o_tdata/o_tlast/o_beat_idx stay stable.
interface ln_stage4_out_serializer_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4,
  parameter int BEAT_W = 4
);
  logic [LANES*DATA_W-1:0] o_tdata;
  logic                    o_tvalid;
  logic                    i_tready;
  logic                    o_tlast;
  logic [BEAT_W-1:0]       o_beat_idx;

  modport master (
    output o_tdata, o_tvalid, o_tlast, o_beat_idx,
    input  i_tready
  );

  modport slave (
    input  o_tdata, o_tvalid, o_tlast, o_beat_idx,
    output i_tready
  );
endinterface

// File: rtl/ln_stage4_out_serializer.sv
// Two-slot result-vector buffer that drains each vector as BEATS beats of LANES
// elements; vectors arriving with both slots busy are dropped and flagged.
module ln_stage4_out_serializer #(
  parameter int DATA_W   = 16,
  parameter int NUM_ELEM = 64,
  parameter int LANES    = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic                         i_res_valid,
  input  logic [NUM_ELEM*DATA_W-1:0]   i_res_data_flat,
  output logic                         o_slot_free,
  output logic                         o_overflow,
  input  logic                         i_clr_overflow,
  ln_stage4_out_serializer_if.master   out_if
);

  localparam int BEATS     = NUM_ELEM / LANES;
  localparam int BEAT_BITS = LANES * DATA_W;
  localparam int BEAT_W    = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // Packed per beat so a slot can be indexed directly by the beat counter.
  logic [BEATS-1:0][BEAT_BITS-1:0] mem_q [2];
  logic [BEATS-1:0][BEAT_BITS-1:0] mem_d [2];

  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              overflow_q, overflow_d;

  logic tvalid;
  logic pop;
  logic pop_last;
  logic push;
  logic drop;

  always_comb begin
    tvalid   = i_en && (count_q != 2'd0);
    pop      = tvalid && out_if.i_tready;
    pop_last = pop && (beat_q == LAST_BEAT);
    // A full buffer still accepts when the head vector retires this cycle.
    push     = i_en && i_res_valid && ((count_q < 2'd2) || pop_last);
    drop     = i_en && i_res_valid && (count_q == 2'd2) && !pop_last;
  end

  always_comb begin
    mem_d      = mem_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_d     = beat_q;
    overflow_d = overflow_q;

    if (push) begin
      mem_d[wr_ptr_q] = i_res_data_flat;
      wr_ptr_d        = ~wr_ptr_q;
    end

    if (pop) begin
      if (pop_last) begin
        beat_d   = '0;
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end

    count_d = count_q + {1'b0, push} - {1'b0, pop_last};

    // Drop takes priority over a same-cycle clear so no loss goes unreported.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (i_clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      beat_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign out_if.o_tvalid   = tvalid;
  assign out_if.o_tdata    = mem_q[rd_ptr_q][beat_q];
  assign out_if.o_tlast    = tvalid && (beat_q == LAST_BEAT);
  assign out_if.o_beat_idx = beat_q;
  assign o_slot_free       = (count_q < 2'd2);
  assign o_overflow        = overflow_q;

endmodule

// File: tb/tb_ln_stage4_out_serializer.sv
// Directed bench for the LayerNorm output serializer: vectors are pushed with
// their expected beats queued; a negedge monitor pops and compares accepted beats.
module tb_ln_stage4_out_serializer;

  localparam int DATA_W   = 16;
  localparam int NUM_ELEM = 64;
  localparam int LANES    = 4;
  localparam int BEATS    = 16;
  localparam int VEC_W    = NUM_ELEM * DATA_W;
  localparam int EXP_W    = 1 + 4 + LANES * DATA_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             res_valid;
  logic             clr_ovf;
  logic [VEC_W-1:0] res_data;
  logic             slot_free;
  logic             overflow;

  ln_stage4_out_serializer_if s_if ();

  int n_checks = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0] exp_q[$];

  logic             stalled = 1'b0;
  logic [EXP_W-1:0] held;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ln_stage4_out_serializer dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_en           (en),
    .i_res_valid    (res_valid),
    .i_res_data_flat(res_data),
    .o_slot_free    (slot_free),
    .o_overflow     (overflow),
    .i_clr_overflow (clr_ovf),
    .out_if         (s_if)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VEC_W-1:0] make_vec(input logic [15:0] base);
    logic [VEC_W-1:0] v;
    for (int k = 0; k < NUM_ELEM; k++) v[16*k +: 16] = base + 16'(k);
    return v;
  endfunction

  task automatic expect_vec(input logic [15:0] base);
    logic [63:0] d;
    for (int b = 0; b < BEATS; b++) begin
      for (int j = 0; j < LANES; j++) d[16*j +: 16] = base + 16'(4*b + j);
      exp_q.push_back({(b == BEATS-1), 4'(b), d});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_vec(input logic [15:0] base, input bit accept);
    res_valid = 1'b1;
    res_data  = make_vec(base);
    if (accept) expect_vec(base);
    step();
    res_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      step();
      n++;
    end
    check({name, " drained"}, 72'(exp_q.size()), 72'd0);
    check({name, " idle"}, 72'(s_if.o_tvalid), 72'd0);
  endtask

  task automatic wait_beat(input logic [3:0] idx, input string name);
    int n = 0;
    while (!(s_if.o_tvalid && s_if.o_beat_idx == idx) && n < 100) begin
      step();
      n++;
    end
    check({name, " reached beat"}, 72'(n < 100), 72'd1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : monitor
    logic [EXP_W-1:0] got;
    logic [EXP_W-1:0] e;
    got = {s_if.o_tlast, s_if.o_beat_idx, s_if.o_tdata};
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled && s_if.o_tvalid) check("stall hold", 72'(got), 72'(held));
      if (s_if.o_tvalid && s_if.i_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected beat: got %h expected none", got);
        end else begin
          e = exp_q.pop_front();
          check("beat", 72'(got), 72'(e));
        end
      end
      stalled = s_if.o_tvalid && !s_if.i_tready;
      held    = got;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int bubbles;
    logic sf_a, sf_b;
    rst = 1'b1; en = 1'b1; res_valid = 1'b0; clr_ovf = 1'b0;
    res_data = '0; s_if.i_tready = 1'b0;
    bubbles = 0; sf_a = 1'b0; sf_b = 1'b0;
    repeat (2) step();
    rst = 1'b0;

    check("reset tvalid", 72'(s_if.o_tvalid), 72'd0);
    check("reset tlast", 72'(s_if.o_tlast), 72'd0);
    check("reset beat_idx", 72'(s_if.o_beat_idx), 72'd0);
    check("reset slot_free", 72'(slot_free), 72'd1);
    check("reset overflow", 72'(overflow), 72'd0);

    // 1: basic streaming
    s_if.i_tready = 1'b1;
    push_vec(16'h0100, 1'b1);
    check("t1 tvalid next cycle", 72'(s_if.o_tvalid), 72'd1);
    check("t1 beat0 data", 72'(s_if.o_tdata), 72'(64'h0103_0102_0101_0100));
    check("t1 beat0 idx", 72'(s_if.o_beat_idx), 72'd0);
    repeat (15) step();
    check("t1 beat15 data", 72'(s_if.o_tdata), 72'(64'h013F_013E_013D_013C));
    check("t1 beat15 tlast", 72'(s_if.o_tlast), 72'd1);
    step();
    check("t1 tvalid after last", 72'(s_if.o_tvalid), 72'd0);
    wait_drain("t1");

    // 2: backpressure pattern 1,0,0,1
    push_vec(16'h0100, 1'b1);
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      s_if.i_tready = ((c % 4) == 0) || ((c % 4) == 3);
      step();
    end
    s_if.i_tready = 1'b1;
    wait_drain("t2");

    // 3: two vectors back-to-back
    push_vec(16'h0100, 1'b1);
    push_vec(16'h0200, 1'b1);
    check("t3 slot_free after 2nd push", 72'(slot_free), 72'd0);
    for (int i = 2; i <= 32; i++) begin
      if (!s_if.o_tvalid) bubbles++;
      if (i == 16) sf_a = slot_free;
      if (i == 17) sf_b = slot_free;
      step();
    end
    check("t3 bubbles", 72'(bubbles), 72'd0);
    check("t3 slot_free at V0 beat15", 72'(sf_a), 72'd0);
    check("t3 slot_free after V0", 72'(sf_b), 72'd1);
    wait_drain("t3");

    // 4a: drop while full and stalled
    s_if.i_tready = 1'b0;
    push_vec(16'h0100, 1'b1);
    push_vec(16'h0200, 1'b1);
    check("t4a slot_free full", 72'(slot_free), 72'd0);
    check("t4a overflow before", 72'(overflow), 72'd0);
    push_vec(16'h0300, 1'b0);
    check("t4a overflow set", 72'(overflow), 72'd1);
    s_if.i_tready = 1'b1;
    wait_drain("t4a");
    check("t4a overflow sticky", 72'(overflow), 72'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("t4a overflow cleared", 72'(overflow), 72'd0);

    // 4b: push on the same edge as V0 beat-15 handshake
    s_if.i_tready = 1'b0;
    push_vec(16'h0100, 1'b1);
    push_vec(16'h0200, 1'b1);
    s_if.i_tready = 1'b1;
    wait_beat(4'd15, "t4b");
    push_vec(16'h0300, 1'b1);
    check("t4b overflow stays 0", 72'(overflow), 72'd0);
    wait_drain("t4b");

    // 5: reset mid-stream
    push_vec(16'h0100, 1'b1);
    push_vec(16'h0200, 1'b1);
    push_vec(16'h0300, 1'b0);
    wait_beat(4'd7, "t5");
    check("t5 overflow before reset", 72'(overflow), 72'd1);
    s_if.i_tready = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    check("t5 tvalid after reset", 72'(s_if.o_tvalid), 72'd0);
    check("t5 beat_idx after reset", 72'(s_if.o_beat_idx), 72'd0);
    check("t5 slot_free after reset", 72'(slot_free), 72'd1);
    check("t5 overflow after reset", 72'(overflow), 72'd0);
    s_if.i_tready = 1'b1;
    repeat (3) step();
    push_vec(16'h0400, 1'b1);
    check("t5 new vector idx", 72'(s_if.o_beat_idx), 72'd0);
    check("t5 new vector data", 72'(s_if.o_tdata), 72'(64'h0403_0402_0401_0400));
    wait_drain("t5");

    // 6: enable freeze, then overflow set/clear priority
    push_vec(16'h0500, 1'b1);
    wait_beat(4'd5, "t6");
    en = 1'b0;
    res_valid = 1'b1;
    res_data = make_vec(16'h0900);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t6 frozen tvalid", 72'(s_if.o_tvalid), 72'd0);
      check("t6 frozen beat_idx", 72'(s_if.o_beat_idx), 72'd5);
      @(posedge clk);
      #1;
    end
    en = 1'b1;
    res_valid = 1'b0;
    #1;
    check("t6 resume tvalid", 72'(s_if.o_tvalid), 72'd1);
    check("t6 resume beat_idx", 72'(s_if.o_beat_idx), 72'd5);
    check("t6 no overflow", 72'(overflow), 72'd0);
    check("t6 no push", 72'(slot_free), 72'd1);
    wait_drain("t6");

    s_if.i_tready = 1'b0;
    push_vec(16'h0100, 1'b1);
    push_vec(16'h0200, 1'b1);
    push_vec(16'h0300, 1'b0);
    check("t6 overflow set", 72'(overflow), 72'd1);
    res_valid = 1'b1;
    res_data = make_vec(16'h0600);
    clr_ovf = 1'b1;
    step();
    res_valid = 1'b0;
    clr_ovf = 1'b0;
    check("t6 set wins over clear", 72'(overflow), 72'd1);
    en = 1'b0;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    en = 1'b1;
    check("t6 clear while disabled", 72'(overflow), 72'd0);
    s_if.i_tready = 1'b1;
    wait_drain("t6 tail");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
